// File: rtl/wave_bank_blender.sv
// Double-banked wave generator manager: loads chord requests into the standby bank,
// swaps banks on a frame tick once ready, and blends old/new waveforms with a decaying coefficient.
module wave_bank_blender #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned HW          = 10,
    parameter int unsigned PW          = 11,
    parameter int unsigned CW          = 10,
    parameter int unsigned BASELINE    = 384,
    parameter int unsigned DECAY       = 724,
    parameter int unsigned DECAY_EVERY = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  vsync,
    input  logic [19:0]           offset,
    input  logic [10:0]           hcount,
    input  logic [5*NCH-1:0]      freq_id_in,
    input  logic [NCH-1:0]        ch_valid_in,
    input  logic                  new_f_in,
    output logic [2*NCH*5-1:0]    bank_freq_id,
    output logic [2*NCH-1:0]      bank_new_f,
    output logic [2*NCH*10-1:0]   bank_index,
    input  logic [2*NCH*HW-1:0]   bank_height,
    input  logic [2*NCH*PW-1:0]   bank_period,
    input  logic [2*NCH-1:0]      bank_ready,
    output logic [HW-1:0]         wave_profile,
    output logic [HW-1:0]         player_profile,
    output logic [19:0]           com_period,
    output logic                  active_bank,
    output logic                  busy,
    output logic                  swap_pulse
);

    localparam int unsigned NG   = 2 * NCH;
    localparam int unsigned IW   = 10;
    localparam int unsigned OW   = 20;
    localparam int unsigned FW   = 5;
    localparam int unsigned MW   = HW + CW + 1;
    localparam int unsigned QW   = OW + PW;
    localparam int unsigned DW   = $clog2(DECAY_EVERY + 1);
    localparam int          SMAX = (1 << HW) - 1;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    localparam logic [OW-1:0] PMAX = {OW{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, SWAP_WAIT} state_t;

    state_t            state_q, state_d;
    logic              vs_q, vs_d;
    logic              tick_q, tick_d;
    logic              pend_q, pend_d;
    logic              active_q, active_d;
    logic              busy_q, busy_d;
    logic              swap_q, swap_d;
    logic [NG*FW-1:0]  freq_q, freq_d;
    logic [NG-1:0]     valid_q, valid_d;
    logic [NCH-1:0]    seen_q, seen_d;
    logic [NG-1:0]     newf_q, newf_d;
    logic [NG*IW-1:0]  index_q, index_d;
    logic [HW-1:0]     wave_q, wave_d;
    logic [HW-1:0]     player_q, player_d;
    logic [OW-1:0]     com_q, com_d;
    logic [CW-1:0]     coeff_q, coeff_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;

    logic              swap_now;
    logic              tgt;
    logic              done;
    logic [NCH-1:0]    stby_valid, stby_ready, seen_acc;
    logic [HW-1:0]     s_act, s_stby;
    logic [MW-1:0]     mix;
    logic [QW-1:0]     prod;
    logic [OW-1:0]     acc;
    logic              any_valid;

    function automatic int unsigned slot(input logic b, input int unsigned c);
        return b ? NCH + c : c;
    endfunction

    // Clamped bank sum: valid heights minus a shared midline for every extra channel
    function automatic logic [HW-1:0] bank_sum(input logic [NG*HW-1:0] h,
                                               input logic [NG-1:0] v,
                                               input logic b);
        int s;
        int n;
        logic [HW-1:0] r;
        s = 0;
        n = 0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (v[slot(b, c)]) begin
                s = s + int'(h[slot(b, c)*HW +: HW]);
                n = n + 1;
            end
        end
        s = s - int'(BASELINE) * (n - 1);
        if (n == 0 || s < 0) r = '0;
        else if (s > SMAX)   r = '1;
        else                 r = HW'(s);
        return r;
    endfunction

    // Bank handshake state machine and request issue
    always_comb begin
        state_d  = state_q;
        swap_now = 1'b0;
        freq_d   = freq_q;
        valid_d  = valid_q;
        newf_d   = '0;

        stby_valid = active_q ? valid_q[NCH-1:0]    : valid_q[NG-1:NCH];
        stby_ready = active_q ? bank_ready[NCH-1:0] : bank_ready[NG-1:NCH];
        seen_acc   = seen_q | (pend_q ? '0 : stby_ready);
        done       = (stby_valid == '0) || (!pend_q && ((seen_acc & stby_valid) == stby_valid));

        case (state_q)
            IDLE:      ;
            CALC:      if (done) state_d = SWAP_WAIT;
            SWAP_WAIT: if (tick_q) begin
                           swap_now = 1'b1;
                           state_d  = IDLE;
                       end
            default:   state_d = IDLE;
        endcase

        active_d = active_q ^ swap_now;
        tgt      = ~active_d;
        seen_d   = (state_q == CALC) ? seen_acc : seen_q;

        if (new_f_in) begin
            state_d = CALC;
            seen_d  = '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                freq_d[slot(tgt, c)*FW +: FW] = freq_id_in[c*FW +: FW];
                valid_d[slot(tgt, c)]         = ch_valid_in[c];
                newf_d[slot(tgt, c)]          = ch_valid_in[c];
            end
        end

        pend_d = new_f_in;
        busy_d = (state_d != IDLE);
        swap_d = swap_now;
        vs_d   = vsync;
        tick_d = vsync & ~vs_q;
    end

    // Indices, profiles, blend coefficient decay and loop period
    always_comb begin
        index_d = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            if (bank_period[g*PW +: PW] == '0)
                index_d[g*IW +: IW] = IW'(hcount);
            else
                index_d[g*IW +: IW] = IW'((offset % OW'(bank_period[g*PW +: PW])) + OW'(hcount));
        end

        s_act    = bank_sum(bank_height, valid_q, active_q);
        s_stby   = bank_sum(bank_height, valid_q, ~active_q);
        mix      = MW'(s_act) * MW'(CMAX - coeff_q) + MW'(s_stby) * MW'(coeff_q);
        wave_d   = s_act;
        player_d = HW'(mix >> CW);

        coeff_d = coeff_q;
        dcnt_d  = dcnt_q;
        if (swap_now) begin
            coeff_d = CMAX;
            dcnt_d  = '0;
        end else if (tick_q) begin
            if (dcnt_q == DW'(DECAY_EVERY - 1)) begin
                dcnt_d  = '0;
                coeff_d = CW'((32'(coeff_q) * 32'(DECAY)) >> 10);
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end

        // Saturating product over the bank that is displayed after this cycle
        acc       = OW'(1);
        prod      = '0;
        any_valid = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (valid_q[slot(active_d, c)]) begin
                any_valid = 1'b1;
                prod      = QW'(acc) * QW'(bank_period[slot(active_d, c)*PW +: PW]);
                acc       = (prod > QW'(PMAX)) ? PMAX : OW'(prod);
            end
        end
        com_d = com_q;
        if (tick_q) com_d = any_valid ? acc : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            swap_q   <= 1'b0;
            freq_q   <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            newf_q   <= '0;
            index_q  <= '0;
            wave_q   <= '0;
            player_q <= '0;
            com_q    <= '0;
            coeff_q  <= CMAX;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            vs_q     <= vs_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            swap_q   <= swap_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            newf_q   <= newf_d;
            index_q  <= index_d;
            wave_q   <= wave_d;
            player_q <= player_d;
            com_q    <= com_d;
            coeff_q  <= coeff_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign bank_freq_id   = freq_q;
    assign bank_new_f     = newf_q;
    assign bank_index     = index_q;
    assign wave_profile   = wave_q;
    assign player_profile = player_q;
    assign com_period     = com_q;
    assign active_bank    = active_q;
    assign busy           = busy_q;
    assign swap_pulse     = swap_q;

endmodule

// File: tb/tb_wave_bank_blender.sv
// Directed bench for wave_bank_blender (default parameters, NCH=2) with hand-computed expectations.
module tb_wave_bank_blender;

    localparam int NCH = 2;
    localparam int HW  = 10;
    localparam int PW  = 11;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 vsync;
    logic [19:0]          offset;
    logic [10:0]          hcount;
    logic [5*NCH-1:0]     freq_id_in;
    logic [NCH-1:0]       ch_valid_in;
    logic                 new_f_in;
    logic [2*NCH*5-1:0]   bank_freq_id;
    logic [2*NCH-1:0]     bank_new_f;
    logic [2*NCH*10-1:0]  bank_index;
    logic [2*NCH*HW-1:0]  bank_height;
    logic [2*NCH*PW-1:0]  bank_period;
    logic [2*NCH-1:0]     bank_ready;
    logic [HW-1:0]        wave_profile;
    logic [HW-1:0]        player_profile;
    logic [19:0]          com_period;
    logic                 active_bank;
    logic                 busy;
    logic                 swap_pulse;

    int checks   = 0;
    int failures = 0;

    wave_bank_blender dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .vsync          (vsync),
        .offset         (offset),
        .hcount         (hcount),
        .freq_id_in     (freq_id_in),
        .ch_valid_in    (ch_valid_in),
        .new_f_in       (new_f_in),
        .bank_freq_id   (bank_freq_id),
        .bank_new_f     (bank_new_f),
        .bank_index     (bank_index),
        .bank_height    (bank_height),
        .bank_period    (bank_period),
        .bank_ready     (bank_ready),
        .wave_profile   (wave_profile),
        .player_profile (player_profile),
        .com_period     (com_period),
        .active_bank    (active_bank),
        .busy           (busy),
        .swap_pulse     (swap_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b1;
        cyc(2);
        vsync = 1'b0;
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n     = 1'b0;
        vsync       = 1'b0;
        offset      = '0;
        hcount      = '0;
        freq_id_in  = '0;
        ch_valid_in = '0;
        new_f_in    = 1'b0;
        bank_height = '0;
        bank_period = '0;
        bank_ready  = '0;
        cyc(3);
        check("rst_wave",   32'(wave_profile),   0);
        check("rst_player", 32'(player_profile), 0);
        check("rst_com",    32'(com_period),     0);
        check("rst_active", 32'(active_bank),    0);
        check("rst_busy",   32'(busy),           0);
        check("rst_newf",   32'(bank_new_f),     0);
        reset_n = 1'b1;
        cyc(1);

        // Index: (offset mod period) + hcount, wrapped to 10 bits
        offset = 20'd250;
        hcount = 11'd5;
        bank_period[0 +: PW] = 11'd100;
        cyc(1);
        check("idx_mod",   32'(bank_index[9:0]),   55);
        check("idx_per0",  32'(bank_index[19:10]), 5);
        hcount = 11'd1020;
        cyc(1);
        check("idx_wrap",  32'(bank_index[9:0]),   46);

        // Request A to standby bank 1
        freq_id_in  = {5'd7, 5'd3};
        ch_valid_in = 2'b11;
        new_f_in    = 1'b1;
        cyc(1);
        new_f_in = 1'b0;
        check("a_newf",  32'(bank_new_f),          32'b1100);
        check("a_freq1", 32'(bank_freq_id[19:10]), 227);
        check("a_freq0", 32'(bank_freq_id[9:0]),   0);
        check("a_busy",  32'(busy),                1);
        cyc(1);
        check("a_newf_off", 32'(bank_new_f), 0);
        bank_ready = 4'b0100;
        cyc(1);
        bank_ready = 4'b0000;
        cyc(3);

        // Request B mid-CALC clears the ch0 ready already seen
        freq_id_in = {5'd9, 5'd5};
        new_f_in   = 1'b1;
        cyc(1);
        new_f_in = 1'b0;
        check("b_newf",  32'(bank_new_f),          32'b1100);
        check("b_freq1", 32'(bank_freq_id[19:10]), 293);
        cyc(1);
        bank_ready = 4'b1000;
        cyc(1);
        bank_ready = 4'b0000;
        frame();
        check("b_noswap_act",  32'(active_bank), 0);
        check("b_noswap_busy", 32'(busy),        1);
        bank_ready = 4'b0100;
        cyc(1);
        bank_ready = 4'b0000;
        check("b_wait_busy", 32'(busy), 1);
        bank_height[2*HW +: HW] = 10'd500;
        bank_height[3*HW +: HW] = 10'd300;

        // Swap on the frame tick
        vsync = 1'b1;
        cyc(1);
        check("sw_pre_act",  32'(active_bank), 0);
        check("sw_pre_pls",  32'(swap_pulse),  0);
        cyc(1);
        check("sw_act",   32'(active_bank), 1);
        check("sw_pulse", 32'(swap_pulse),  1);
        check("sw_busy",  32'(busy),        0);
        vsync = 1'b0;
        cyc(1);
        check("sw_pulse_off", 32'(swap_pulse),     0);
        check("wave_416",     32'(wave_profile),   416);
        check("player_c1023", 32'(player_profile), 0);

        // Coefficient decay every 8 ticks
        repeat (7) frame();
        check("player_t7",  32'(player_profile), 0);
        frame();
        check("player_t8",  32'(player_profile), 121);
        repeat (7) frame();
        check("player_t15", 32'(player_profile), 121);
        frame();
        check("player_t16", 32'(player_profile), 208);

        bank_height[2*HW +: HW] = 10'd100;
        bank_height[3*HW +: HW] = 10'd100;
        cyc(1);
        check("wave_clamp0", 32'(wave_profile), 0);
        bank_height[2*HW +: HW] = 10'd500;
        bank_height[3*HW +: HW] = 10'd300;
        cyc(1);

        bank_period[2*PW +: PW] = 11'd1200;
        bank_period[3*PW +: PW] = 11'd1100;
        frame();
        check("com_sat", 32'(com_period), 1048575);

        // Request C (ch0 only) to bank 0, then request D coinciding with the swap tick
        freq_id_in  = {5'd2, 5'd1};
        ch_valid_in = 2'b01;
        new_f_in    = 1'b1;
        cyc(1);
        new_f_in = 1'b0;
        check("c_newf", 32'(bank_new_f), 32'b0001);
        cyc(1);
        bank_ready = 4'b0001;
        cyc(1);
        bank_ready = 4'b0000;
        check("c_busy", 32'(busy), 1);
        bank_period[0 +: PW]    = 11'd600;
        bank_height[0 +: HW]    = 10'd450;
        vsync = 1'b1;
        cyc(1);
        freq_id_in  = {5'd6, 5'd4};
        ch_valid_in = 2'b11;
        new_f_in    = 1'b1;
        cyc(1);
        new_f_in = 1'b0;
        vsync    = 1'b0;
        check("d_act",   32'(active_bank),         0);
        check("d_pulse", 32'(swap_pulse),          1);
        check("d_newf",  32'(bank_new_f),          32'b1100);
        check("d_freq1", 32'(bank_freq_id[19:10]), 196);
        check("d_busy",  32'(busy),                1);
        check("com_600", 32'(com_period),          600);
        cyc(1);
        check("d_wave",   32'(wave_profile),   450);
        check("d_player", 32'(player_profile), 415);
        bank_ready = 4'b1100;
        cyc(1);
        bank_ready = 4'b0000;
        check("d_wait_busy", 32'(busy), 1);

        // Asynchronous reset in SWAP_WAIT
        reset_n = 1'b0;
        #2;
        check("ar_wave",   32'(wave_profile),   0);
        check("ar_player", 32'(player_profile), 0);
        check("ar_com",    32'(com_period),     0);
        check("ar_freq",   32'(bank_freq_id),   0);
        check("ar_busy",   32'(busy),           0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        frame();
        frame();
        check("ar_noswap_act", 32'(active_bank), 0);
        check("ar_busy_post",  32'(busy),        0);
        check("ar_newf_post",  32'(bank_new_f),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
